// File: rtl/cpu_trace_capture.sv
// rtl/cpu_trace_capture.sv - CPU trace capture FIFO with 5-word packet streamer
// Samples the CPU probe words into a record FIFO and streams each record as a framed packet.

module cpu_trace_capture #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [31:0]   test_inst,
    input  logic [31:0]   t_file0,
    input  logic [31:0]   t_file1,
    input  logic [31:0]   t_file2,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          overflow,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  drops;
        logic [31:0] inst;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] f2;
    } rec_t;

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, W4} state_t;

    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    rec_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [15:0]   cyc;
    logic [7:0]    drops;
    state_t        state;
    state_t        state_next;

    logic          hs;
    logic          pop;
    logic          push;
    logic          full;
    logic [AW:0]   count_next;
    logic [AW-1:0] rd_next_idx;
    rec_t          in_rec;
    rec_t          cur_rec;
    rec_t          nxt_rec;
    rec_t          src_rec;
    logic [31:0]   data_next;
    logic          valid_next;
    logic          last_next;

    assign hs   = out_valid && out_ready;
    assign pop  = (state == W4) && hs;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still takes a record when the head is leaving on the same edge.
    assign push = en && (!full || pop);

    assign in_rec      = {cyc, drops, test_inst, t_file0, t_file1, t_file2};
    assign cur_rec     = mem[rd_ptr[AW-1:0]];
    assign rd_next_idx = rd_ptr[AW-1:0] + IDX_ONE;
    // With one record left, the next head is the one being written right now.
    assign nxt_rec     = (count == PTR_ONE) ? in_rec : mem[rd_next_idx];
    assign src_rec     = pop ? nxt_rec : cur_rec;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + PTR_ONE;
            2'b01:   count_next = count - PTR_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr[AW-1:0]] <= in_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cyc      <= '0;
            drops    <= '0;
            overflow <= 1'b0;
        end else begin
            cyc   <= cyc + 16'd1;
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                drops <= '0;
            end else if (en) begin
                overflow <= 1'b1;
                if (drops != 8'hFF) begin
                    drops <= drops + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = W0;
            W0:      if (hs) state_next = W1;
            W1:      if (hs) state_next = W2;
            W2:      if (hs) state_next = W3;
            W3:      if (hs) state_next = W4;
            W4:      if (hs) state_next = (count_next != '0) ? W0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_next  = '0;
        valid_next = 1'b0;
        last_next  = 1'b0;
        case (state_next)
            W0: begin
                data_next  = {8'hC5, src_rec.drops, src_rec.cyc};
                valid_next = 1'b1;
            end
            W1: begin
                data_next  = src_rec.inst;
                valid_next = 1'b1;
            end
            W2: begin
                data_next  = src_rec.f0;
                valid_next = 1'b1;
            end
            W3: begin
                data_next  = src_rec.f1;
                valid_next = 1'b1;
            end
            W4: begin
                data_next  = src_rec.f2;
                valid_next = 1'b1;
                last_next  = 1'b1;
            end
            default: begin
                data_next  = '0;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_data  <= data_next;
            out_valid <= valid_next;
            out_last  <= last_next;
        end
    end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb/tb_cpu_trace_capture.sv - scoreboard bench for cpu_trace_capture
// Stimulus queues expected packet words; a negedge monitor pops and compares on each handshake.

module tb_cpu_trace_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] test_inst = '0;
    logic [31:0] t_file0 = '0;
    logic [31:0] t_file1 = '0;
    logic [31:0] t_file2 = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        overflow;
    logic [4:0]  count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [15:0] cyc = '0;

    always #5 clk = ~clk;

    cpu_trace_capture #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .test_inst (test_inst),
        .t_file0   (t_file0),
        .t_file1   (t_file1),
        .t_file2   (t_file2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %08h expected no word", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream_word", out_data, mon_e[31:0]);
                chk("stream_last", 32'(out_last), 32'(mon_e[32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) cyc = cyc + 16'd1;
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [15:0] c, input logic [31:0] i,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] f);
        exp_q.push_back({1'b0, 8'hC5, d, c});
        exp_q.push_back({1'b0, i});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b1, f});
    endtask

    task automatic capture(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] f, input bit acc, input logic [7:0] d);
        test_inst = i;
        t_file0   = a;
        t_file1   = b;
        t_file2   = f;
        en        = 1'b1;
        if (acc) push_exp(d, cyc, i, a, b, f);
        tick();
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        cyc = '0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || count != 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
    endtask

    task automatic wait_last(input int budget);
        int k = 0;
        while (!(out_valid && out_last) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_last_timeout: got no final word expected one");
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        // Reset then single capture at cyc 0x0003
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        test_inst = 32'h20080005;
        t_file0 = 32'd1;
        t_file1 = 32'd2;
        t_file2 = 32'd3;
        exp_q.push_back({1'b0, 32'hC5000003});
        exp_q.push_back({1'b0, 32'h20080005});
        exp_q.push_back({1'b0, 32'h00000001});
        exp_q.push_back({1'b0, 32'h00000002});
        exp_q.push_back({1'b1, 32'h00000003});
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("single_count_after_push", 32'(count), 32'd1);
        drain(20);
        chk("single_count_end", 32'(count), 32'd0);

        // Push landing on the W4 handshake of the only record
        capture(32'h11111111, 32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 1'b1, 8'h00);
        wait_last(20);
        capture(32'h22222222, 32'h0000DDDD, 32'h0000EEEE, 32'h0000FFFF, 1'b1, 8'h00);
        chk("handoff_count", 32'(count), 32'd1);
        drain(30);
        chk("handoff_count_end", 32'(count), 32'd0);

        // Backpressure held at W2 for four cycles
        capture(32'h20080005, 32'd1, 32'd2, 32'd3, 1'b1, 8'h00);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h00000001);
            tick();
        end
        drain(20);
        chk("bp_count_end", 32'(count), 32'd0);

        // Overflow: DEPTH+3 captures with the sink stalled
        do_reset();
        for (int i = 0; i < 19; i++) begin
            capture(32'hA0000000 + 32'(i), 32'(i), ~32'(i), 32'h5A000000 ^ 32'(i), (i < 16), 8'h00);
        end
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain(200);
        chk("ovf_count_drained", 32'(count), 32'd0);
        capture(32'hBEEF0001, 32'h0000000A, 32'h0000000B, 32'h0000000C, 1'b1, 8'h03);
        drain(20);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a push on the W4 handshake
        do_reset();
        for (int i = 0; i < 16; i++) begin
            capture(32'hC0000000 + 32'(i), 32'(i) << 4, 32'(i) << 8, 32'(i) << 12, 1'b1, 8'h00);
        end
        chk("full_count", 32'(count), 32'd16);
        out_ready = 1'b1;
        wait_last(20);
        capture(32'hD00DFEED, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b1, 8'h00);
        chk("full_pop_count", 32'(count), 32'd16);
        chk("full_pop_overflow", 32'(overflow), 32'd0);
        drain(200);
        chk("full_count_end", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a packet
        do_reset();
        out_ready = 1'b1;
        capture(32'hE0E0E0E0, 32'h00000101, 32'h00000202, 32'h00000303, 1'b1, 8'h00);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_data", out_data, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        cyc = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("async_stale_valid", 32'(out_valid), 32'd0);
        chk("async_stale_count", 32'(count), 32'd0);

        // Drop saturation, then headers straddling the cycle counter wrap
        do_reset();
        for (int i = 0; i < 316; i++) begin
            capture(32'hF0000000 + 32'(i), 32'(i), 32'(i) + 32'd7, 32'(i) ^ 32'hFFFF0000, (i < 16), 8'h00);
        end
        chk("sat_count", 32'(count), 32'd16);
        chk("sat_overflow", 32'(overflow), 32'd1);
        drain(200);
        begin
            int k = 0;
            while (cyc != 16'hFFFF && k < 70000) begin
                tick();
                k++;
            end
            if (k >= 70000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cyc_wait_timeout: got %04h expected ffff", cyc);
            end
        end
        capture(32'h0BADC0DE, 32'h00000011, 32'h00000022, 32'h00000033, 1'b1, 8'hFF);
        capture(32'h0BADC0DF, 32'h00000044, 32'h00000055, 32'h00000066, 1'b1, 8'h00);
        drain(40);
        chk("wrap_count_end", 32'(count), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Receiving end of the CPU debug/observation interface. Each clock it samples the CPU's test_inst and the three register-file probe words into a trace FIFO.
- Buffered records are streamed out as 5-word packets over a valid/ready word stream, to a host link or a bench scoreboard.
- Sits beside CPU in the top level, on the same clk and rst.

Parameters:
- DEPTH, 16, trace FIFO depth in records; must be a power of two, at least 2.
- AW, 4, log2(DEPTH); FIFO pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; sampled every rising edge.
- test_inst  input  32  instruction currently executing in CPU.
- t_file0  input  32  register-file probe word 0.
- t_file1  input  32  register-file probe word 1.
- t_file2  input  32  register-file probe word 2.
- out_data  output  32  stream word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts a word when high together with out_valid.
- out_last  output  1  high on the final word (word 4) of a packet.
- overflow  output  1  sticky; set when any record is dropped.
- count  output  AW+1  records currently in the FIFO, 0..DEPTH.

Behaviour:
- Reset: rst=0 asynchronously forces all state to zero: FIFO pointers, count, FSM=IDLE, cycle counter, drop counter and overflow.
  - While rst=0: out_valid=0, out_last=0, out_data=0, overflow=0, count=0.
  - Reset mid-packet discards the packet immediately. No partial resume after release.
- Cycle counter:
  - 16-bit free-running; increments every rising edge with rst=1.
  - Wraps 0xFFFF -> 0x0000.
- Capture:
  - At a rising edge with en=1, push record {cyc, test_inst, t_file0, t_file1, t_file2}; cyc is the counter value before that edge's increment.
  - Push is accepted if count<DEPTH, or if a pop completes on the same edge (full + simultaneous pop is accepted; count unchanged).
  - Otherwise the record is dropped: overflow<=1, drop counter increments, saturating at 255.
- Drop counter:
  - The value attached to a record is the drop counter at the edge the record is accepted.
  - The counter clears on that same edge.
- Packet format, in order:
  - word0 = {8'hC5, drops[7:0], cyc[15:0]}
  - word1 = test_inst
  - word2 = t_file0
  - word3 = t_file1
  - word4 = t_file2, with out_last=1
- Output FSM states: IDLE, W0, W1, W2, W3, W4.
  - IDLE -> W0 when count>0; out_valid rises on that edge. Minimum latency: a record pushed at edge k is presented at edge k+1 when the FSM is IDLE.
  - Wn -> Wn+1 on an edge with out_valid&&out_ready.
  - W4 handshake pops the FIFO. Then go to W0 if another record remains after the pop, else IDLE. Back-to-back packets have no idle cycle.
- Stream rules:
  - out_data, out_last and out_valid are registered.
  - Once out_valid=1, they hold stable until a handshake.
  - out_valid never deasserts without a handshake, except on reset.
  - out_ready may be held high permanently, giving a throughput of 1 word per cycle (1 packet per 5 cycles).
- Rate and full condition:
  - Continuous en=1 with out_ready=1 fills the FIFO, because capture is 1 record/cycle and drain is 1 record per 5 cycles.
  - Drops are then expected and must be accounted in the drop field and overflow.
- count:
  - Increments on an accepted push without pop.
  - Decrements on a pop without push.
  - Unchanged on both or neither.
  - The record being streamed stays counted until its W4 handshake.
- FIFO pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

Test Plan:
- Reset then single capture: hold rst=0 for 2 cycles, release; pulse en for 1 cycle at cyc=0x0003 with inst=0x20080005, files=1,2,3, out_ready=1 -> packet C5000003, 20080005, 00000001, 00000002, 00000003; out_last only on the 5th word; count returns 0.
- Backpressure: same single capture with out_ready low for 4 cycles at W2 -> out_data stays 00000001 and out_valid stays 1 throughout; stream completes correctly once out_ready rises.
- Overflow: out_ready=0, en=1 for DEPTH+3 cycles (DEPTH=16) -> count=16, overflow=1.
  - Then raise out_ready with en=0 -> 16 packets, all drop fields 00.
  - Next accepted record carries drop field 0x03.
- Full + simultaneous pop: FIFO full, en=1 on the edge of a W4 handshake -> record accepted, count stays 16, overflow unchanged.
- Drop saturation and cycle-counter wrap: 300 drops -> drop field 0xFF. Capture straddling cyc 0xFFFF/0x0000 -> consecutive headers end in FFFF then 0000.
- Async reset mid-packet: assert rst=0 between edges during W2 -> out_valid drops immediately and count=0. After release, no stale words are emitted.
